alu_arbiter: RTL and testbench

- Shares one combinational `alu` instance between two requesters, for example the execute stage and a debug/DMA port.
- Each requester uses a valid/ready request channel and receives results on a single shared, tagged response channel.
- Round-robin arbitration, a two-stage registered pipeline (operand latch, result latch) and an architectural NZCV flag register with conditional update.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_arbiter_if.sv | 40 ++++
 rtl/alu_arbiter_rr_arb2.sv | 29 ++
 rtl/alu_arbiter.sv | 100 ++++++++++
 tb/tb_alu_arbiter.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU arbiter definitions: op codes, flag bit positions and the request layout.
// Fields wider than the configured datapath are zero-extended into alu_req_t.
package alu_pkg;

  typedef logic [1:0] alu_op_t;

  localparam alu_op_t ADD = 2'b00;
  localparam alu_op_t SUB = 2'b01;
  localparam alu_op_t AND = 2'b10;
  localparam alu_op_t OR  = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int ALU_W = 32;

  // Request as seen at the default 32-bit width.
  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    alu_op_t          op;
    logic             setflags;
    logic             id;
  } alu_req_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bus between two requesters, the response consumer and the external ALU.
// slave = arbiter side, master = everything around it.
interface alu_arbiter_if #(parameter int N = 32);
  import alu_pkg::*;

  logic         req0_valid, req0_ready, req0_setflags;
  logic [N-1:0] req0_a, req0_b;
  alu_op_t      req0_op;
  logic         req1_valid, req1_ready, req1_setflags;
  logic [N-1:0] req1_a, req1_b;
  alu_op_t      req1_op;

  logic         resp_valid, resp_ready, resp_id;
  logic [N-1:0] resp_result;
  logic [3:0]   resp_flags, flags_q;

  logic [N-1:0] alu_a, alu_b, alu_result;
  alu_op_t      alu_ctrl;
  logic [3:0]   alu_flags;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, req0_setflags,
    input  req1_valid, req1_a, req1_b, req1_op, req1_setflags,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_result, resp_flags, flags_q,
    input  resp_ready,
    output alu_a, alu_b, alu_ctrl,
    input  alu_result, alu_flags
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op, req0_setflags,
    output req1_valid, req1_a, req1_b, req1_op, req1_setflags,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_result, resp_flags, flags_q,
    output resp_ready,
    input  alu_a, alu_b, alu_ctrl,
    output alu_result, alu_flags
  );
endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant; last_q remembers the last accepted requester.
// Reset value 1 makes requester 0 win the first contended cycle.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic       last_q, last_d;
  logic [1:0] pick;

  always_comb begin
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last_q ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
    gnt    = en ? pick : 2'b00;
    last_d = last_q;
    if (gnt[0])      last_d = 1'b0;
    else if (gnt[1]) last_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) last_q <= 1'b1;
    else        last_q <= last_d;
endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters through a two-stage
// pipeline (operand latch S1, result latch S2) with a conditionally updated NZCV register.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);
  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    alu_op_t      op;
    logic         setflags;
    logic         id;
  } s1_t;

  s1_t          s1_q, s1_d;
  logic         s1_v_q, s1_v_d, o_v_q, o_v_d, id_q, id_d;
  logic [N-1:0] res_q, res_d;
  logic [3:0]   rflg_q, rflg_d, flg_q, flg_d;
  logic         s2_load, s1_free;
  logic [1:0]   gnt;

  always_comb begin
    s2_load = s1_v_q && (!o_v_q || bus.resp_ready);
    s1_free = !s1_v_q || s2_load;
  end

  // Grants are suppressed while reset is held so no request sees ready.
  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (s1_free && reset),
    .req   ({bus.req1_valid, bus.req0_valid}),
    .gnt   (gnt)
  );

  always_comb begin
    s1_d   = s1_q;
    s1_v_d = s1_v_q && !s2_load;
    if (gnt[0]) begin
      s1_d   = '{a: bus.req0_a, b: bus.req0_b, op: bus.req0_op,
                 setflags: bus.req0_setflags, id: 1'b0};
      s1_v_d = 1'b1;
    end else if (gnt[1]) begin
      s1_d   = '{a: bus.req1_a, b: bus.req1_b, op: bus.req1_op,
                 setflags: bus.req1_setflags, id: 1'b1};
      s1_v_d = 1'b1;
    end
  end

  // S2 captures the ALU output in the same cycle S1 presents the operands.
  always_comb begin
    o_v_d  = s2_load ? 1'b1 : (bus.resp_ready ? 1'b0 : o_v_q);
    res_d  = res_q;
    rflg_d = rflg_q;
    id_d   = id_q;
    flg_d  = flg_q;
    if (s2_load) begin
      res_d  = bus.alu_result;
      rflg_d = bus.alu_flags;
      id_d   = s1_q.id;
      if (s1_q.setflags) flg_d = bus.alu_flags;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q   <= '0;
      s1_v_q <= 1'b0;
      o_v_q  <= 1'b0;
      res_q  <= '0;
      rflg_q <= '0;
      id_q   <= 1'b0;
      flg_q  <= '0;
    end else begin
      s1_q   <= s1_d;
      s1_v_q <= s1_v_d;
      o_v_q  <= o_v_d;
      res_q  <= res_d;
      rflg_q <= rflg_d;
      id_q   <= id_d;
      flg_q  <= flg_d;
    end
  end

  assign bus.req0_ready  = gnt[0];
  assign bus.req1_ready  = gnt[1];
  assign bus.resp_valid  = o_v_q;
  assign bus.resp_id     = id_q;
  assign bus.resp_result = res_q;
  assign bus.resp_flags  = rflg_q;
  assign bus.flags_q     = flg_q;
  assign bus.alu_a       = s1_v_q ? s1_q.a  : '0;
  assign bus.alu_b       = s1_v_q ? s1_q.b  : '0;
  assign bus.alu_ctrl    = s1_v_q ? s1_q.op : '0;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter at N=4 with a bit-level ALU stand-in and an
// operation-queue model checked every cycle, plus literal expectations per scenario.
module tb_alu_arbiter;
  import alu_pkg::*;
  localparam int W = 4;

  logic clk, reset;
  int n_chk = 0, n_err = 0;

  alu_arbiter_if #(.N(W)) bus ();
  alu_arbiter #(.N(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stand-in
  logic [W:0]   stub_sum;
  logic [W-1:0] stub_bx, stub_res;
  logic         stub_c, stub_v;
  always_comb begin
    stub_bx  = (bus.alu_ctrl == SUB) ? ~bus.alu_b : bus.alu_b;
    stub_sum = {1'b0, bus.alu_a} + {1'b0, stub_bx} + {{W{1'b0}}, bus.alu_ctrl == SUB};
    stub_res = stub_sum[W-1:0];
    stub_c   = stub_sum[W];
    stub_v   = (bus.alu_a[W-1] == stub_bx[W-1]) && (stub_res[W-1] != bus.alu_a[W-1]);
    if (bus.alu_ctrl == AND) begin
      stub_res = bus.alu_a & bus.alu_b; stub_c = 1'b0; stub_v = 1'b0;
    end else if (bus.alu_ctrl == OR) begin
      stub_res = bus.alu_a | bus.alu_b; stub_c = 1'b0; stub_v = 1'b0;
    end
    bus.alu_result         = stub_res;
    bus.alu_flags          = '0;
    bus.alu_flags[FLAG_N]  = stub_res[W-1];
    bus.alu_flags[FLAG_Z]  = (stub_res == '0);
    bus.alu_flags[FLAG_C]  = stub_c;
    bus.alu_flags[FLAG_V]  = stub_v;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference arithmetic on plain integers: returns {result, N, Z, C, V}.
  function automatic logic [7:0] ref_op(input int a, input int b, input logic [1:0] op);
    int r, sa, sb, sr;
    logic c, v;
    logic [3:0] res;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    r = 0; c = 0; v = 0;
    case (op)
      ADD: begin r = a + b; sr = sa + sb; c = (r >= 16); v = (sr > 7) || (sr < -8); end
      SUB: begin r = a - b; sr = sa - sb; c = (a >= b);  v = (sr > 7) || (sr < -8); end
      AND: r = a & b;
      default: r = a | b;
    endcase
    res = 4'(r & 15);
    return {res, (res >= 4'd8), (res == 4'd0), c, v};
  endfunction

  typedef struct {
    logic       id;
    logic [3:0] a, b, res, fl;
    logic [1:0] op;
    logic       sf;
    bit         shown;
  } mop_t;
  typedef struct { logic id; logic [3:0] res, fl; } rsp_t;

  mop_t m_q[$];
  rsp_t rlog[$];
  logic [3:0] m_flags;
  bit m_last;

  // Model: queue of in-flight ops; the head becomes visible one edge after acceptance
  // and leaves when consumed. At most one visible and one waiting op.
  initial begin
    bit shown, waiting, pop, move, freeb, g0, g1;
    logic [7:0] r;
    mop_t t;
    m_flags = '0; m_last = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_q.delete(); m_flags = '0; m_last = 1'b1;
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_ready", {bus.req1_ready, bus.req0_ready}, 0);
        chk("rst_flags_q", bus.flags_q, 0);
        chk("rst_alu_ports", {bus.alu_a, bus.alu_b, bus.alu_ctrl}, 0);
      end else begin
        shown   = (m_q.size() > 0) && m_q[0].shown;
        waiting = (m_q.size() > 0) && !m_q[$].shown;
        pop     = shown && bus.resp_ready;
        move    = waiting && (!shown || pop);
        freeb   = !waiting || move;
        g0 = 0; g1 = 0;
        if (freeb) begin
          if (bus.req0_valid && bus.req1_valid) begin g0 = m_last; g1 = !m_last; end
          else begin g0 = bus.req0_valid; g1 = bus.req1_valid; end
        end
        chk("resp_valid", bus.resp_valid, shown);
        if (shown) begin
          chk("resp_id", bus.resp_id, m_q[0].id);
          chk("resp_result", bus.resp_result, m_q[0].res);
          chk("resp_flags", bus.resp_flags, m_q[0].fl);
        end
        chk("ready", {bus.req1_ready, bus.req0_ready}, {g1, g0});
        chk("flags_q", bus.flags_q, m_flags);
        if (waiting) chk("alu_ports", {bus.alu_a, bus.alu_b, bus.alu_ctrl},
                         {m_q[$].a, m_q[$].b, m_q[$].op});
        else         chk("alu_idle", {bus.alu_a, bus.alu_b, bus.alu_ctrl}, 0);
        if (pop) begin
          rlog.push_back('{id: bus.resp_id, res: bus.resp_result, fl: bus.resp_flags});
          void'(m_q.pop_front());
        end
        if (move) begin
          t = m_q[0]; t.shown = 1'b1; m_q[0] = t;
          if (t.sf) m_flags = t.fl;
        end
        if (g0 || g1) begin
          t.id = g1;
          t.a  = g1 ? bus.req1_a  : bus.req0_a;
          t.b  = g1 ? bus.req1_b  : bus.req0_b;
          t.op = g1 ? bus.req1_op : bus.req0_op;
          t.sf = g1 ? bus.req1_setflags : bus.req0_setflags;
          r = ref_op(int'(t.a), int'(t.b), t.op);
          t.res = r[7:4]; t.fl = r[3:0]; t.shown = 1'b0;
          m_q.push_back(t);
          m_last = g1;
        end
      end
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic set0(input logic v, input logic [3:0] a, b, input logic [1:0] op, input logic sf);
    bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_setflags = sf;
  endtask

  task automatic set1(input logic v, input logic [3:0] a, b, input logic [1:0] op, input logic sf);
    bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_setflags = sf;
  endtask

  task automatic wait_acc0();
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk); got = bus.req0_ready;
      @(posedge clk); #1;
    end
    chk("accept_timeout", got, 1);
  endtask

  task automatic issue0(input logic [3:0] a, b, input logic [1:0] op, input logic sf);
    set0(1'b1, a, b, op, sf);
    wait_acc0();
    bus.req0_valid = 1'b0;
  endtask

  task automatic chk_log(input string nm, input int idx, input logic id, input logic [3:0] res, fl);
    if (idx < rlog.size()) chk(nm, {rlog[idx].id, rlog[idx].res, rlog[idx].fl}, {id, res, fl});
    else                   chk({nm, "_missing"}, rlog.size(), idx + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    set0(1'b0, 4'd0, 4'd0, ADD, 1'b0);
    set1(1'b0, 4'd0, 4'd0, ADD, 1'b0);
    bus.resp_ready = 1'b1;
    #1 reset = 1'b0;
    bus.req0_valid = 1'b1;
    #11;
    chk("reset_state", {bus.resp_valid, bus.resp_id, bus.resp_result, bus.resp_flags, bus.flags_q},
        0);
    chk("reset_ready_low", bus.req0_ready, 0);
    bus.req0_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;

    // Contention: grants alternate starting with requester 0
    rlog.delete();
    set0(1'b1, 4'd3, 4'd5, SUB, 1'b0);
    set1(1'b1, 4'b1100, 4'b1010, AND, 1'b0);
    cyc(4);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    cyc(3);
    chk("contention_count", rlog.size(), 4);
    chk_log("cont0", 0, 1'b0, 4'b1110, 4'b1000);
    chk_log("cont1", 1, 1'b1, 4'b1000, 4'b1000);
    chk_log("cont2", 2, 1'b0, 4'b1110, 4'b1000);
    chk_log("cont3", 3, 1'b1, 4'b1000, 4'b1000);

    // Single op with flag update
    set0(1'b1, 4'd5, 4'd3, ADD, 1'b1);
    cyc(1);
    bus.req0_valid = 1'b0;
    cyc(1);
    chk("single_resp", {bus.resp_valid, bus.resp_id, bus.resp_result, bus.resp_flags},
        {1'b1, 1'b0, 4'd8, 4'b1001});
    chk("single_flags_q", bus.flags_q, 4'b1001);
    cyc(2);
    chk("single_idle", {bus.resp_valid, bus.alu_a}, 0);

    // Back-pressure: two in flight, third waits
    rlog.delete();
    bus.resp_ready = 1'b0;
    issue0(4'd1, 4'd2, ADD, 1'b0);
    issue0(4'd4, 4'd2, ADD, 1'b0);
    set0(1'b1, 4'd1, 4'd8, OR, 1'b0);
    cyc(3);
    chk("bp_ready_low", bus.req0_ready, 0);
    chk("bp_resp_stable", {bus.resp_valid, bus.resp_result}, {1'b1, 4'd3});
    bus.resp_ready = 1'b1;
    wait_acc0();
    bus.req0_valid = 1'b0;
    cyc(4);
    chk_log("bp0", 0, 1'b0, 4'd3, 4'b0000);
    chk_log("bp1", 1, 1'b0, 4'd6, 4'b0000);
    chk_log("bp2", 2, 1'b0, 4'd9, 4'b1000);

    // Conditional flags
    rlog.delete();
    issue0(4'd8, 4'd8, ADD, 1'b0);
    cyc(2);
    chk("cond_hold", bus.flags_q, 4'b1001);
    chk_log("cond_add", 0, 1'b0, 4'd0, 4'b0111);
    issue0(4'd0, 4'd0, OR, 1'b1);
    cyc(2);
    chk("cond_update", bus.flags_q, 4'b0100);

    // Async reset with two ops in flight
    bus.resp_ready = 1'b0;
    issue0(4'd0, 4'd1, SUB, 1'b1);
    issue0(4'd2, 4'd2, ADD, 1'b1);
    chk("pre_reset_flags", bus.flags_q, 4'b1000);
    #2 reset = 1'b0;
    #1;
    chk("async_reset", {bus.resp_valid, bus.flags_q, bus.alu_a, bus.alu_ctrl}, 0);
    rlog.delete();
    @(posedge clk); #1 reset = 1'b1;
    bus.resp_ready = 1'b1;
    cyc(3);
    chk("no_stale_resp", rlog.size(), 0);
    set0(1'b1, 4'd2, 4'd3, SUB, 1'b1);
    set1(1'b1, 4'd5, 4'd5, OR, 1'b0);
    @(negedge clk);
    chk("post_reset_grant", {bus.req1_ready, bus.req0_ready}, 2'b01);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    cyc(2);
    chk("post_reset_flags", bus.flags_q, 4'b1000);
    chk_log("post_reset_resp", 0, 1'b0, 4'hF, 4'b1000);

    // Idle
    cyc(5);
    chk("idle", {bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.resp_valid}, 0);
    chk("idle_flags", bus.flags_q, 4'b1000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
